// File: rtl/pipeline_mem_wb_pkg.sv
// Shared encodings and stage bundles for the MIPS back end:
// EX/MEM register, data-memory access and MEM/WB register.
package pipeline_mem_wb_pkg;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_PC   = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic        valid;
    logic        regWr;
    logic        memRd;
    logic        memWr;
    logic [1:0]  memToReg;
    logic [4:0]  destiny;
    logic [31:0] aluOut;
    logic [31:0] dataB;
    logic [31:0] pc;
  } mem_stage_t;

  typedef struct packed {
    logic        valid;
    logic        regWr;
    logic [1:0]  memToReg;
    logic [4:0]  destiny;
    logic [31:0] aluOut;
    logic [31:0] pc;
    logic [31:0] rdata;
  } wb_stage_t;

endpackage

// File: rtl/pipeline_mem_wb_mem_access.sv
// Data-memory handshake controller: request/stall/error generation plus a
// watchdog that forces completion when mem_ack never arrives.
module mem_access_fsm
  import pipeline_mem_wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic acc_i,
  input  logic aligned_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic mem_stall_o,
  output logic mem_err_o,
  output logic data_ok_o
);

  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue;
  logic             timeoutHit;

  assign issue       = acc_i & aligned_i;
  assign timeoutHit  = issue & (state_q == WAIT) & (cnt_q == CNT_W'(TIMEOUT - 1)) & ~mem_ack_i;
  assign mem_req_o   = issue;
  // Stall from the very first cycle so a zero-wait ack never freezes the pipe.
  assign mem_stall_o = issue & ~(mem_ack_i | timeoutHit);
  assign mem_err_o   = (acc_i & ~aligned_i) | timeoutHit;
  assign data_ok_o   = issue & mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue && !mem_ack_i) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!issue || mem_ack_i || timeoutHit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_mem_wb.sv
// MIPS back end: EX/MEM register, memory stage with handshake, MEM/WB register,
// register-file write port and MEM-stage forwarding to the decode branch compare.
module pipeline_mem_wb
  import pipeline_mem_wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [31:0] EX_ALUout,
  input  logic [31:0] EX_dataB,
  input  logic [31:0] EX_PC,
  input  logic [1:0]  EX_MemToReg,
  input  logic        EX_RegWr,
  input  logic        EX_MemRd,
  input  logic        EX_MemWr,
  input  logic [4:0]  EX_Destiny,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_stall,
  output logic        load_hazard,
  output logic        mem_err,
  output logic [31:0] Mem_in,
  output logic        ForwardC,
  output logic        ForwardD,
  output logic        WB_RegWr,
  output logic [4:0]  WB_Destiny,
  output logic [31:0] WB_out
);

  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q, wb_d;
  logic       acc, aligned, dataOk, hitRs, hitRt;

  assign acc     = mem_q.valid & (mem_q.memRd | mem_q.memWr);
  assign aligned = (mem_q.aluOut[1:0] == 2'b00);

  mem_access_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fsm (
    .clk_i       (clk),
    .rst_ni      (reset),
    .acc_i       (acc),
    .aligned_i   (aligned),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_stall_o (mem_stall),
    .mem_err_o   (mem_err),
    .data_ok_o   (dataOk)
  );

  always_comb begin
    mem_d = mem_q;
    if (!mem_stall) begin
      mem_d.valid    = EX_valid;
      mem_d.regWr    = EX_RegWr;
      mem_d.memRd    = EX_MemRd;
      mem_d.memWr    = EX_MemWr;
      mem_d.memToReg = EX_MemToReg;
      mem_d.destiny  = EX_Destiny;
      mem_d.aluOut   = EX_ALUout;
      mem_d.dataB    = EX_dataB;
      mem_d.pc       = EX_PC;
    end
  end

  // A stalled edge pushes a bubble into WB so the older instruction retires once.
  always_comb begin
    wb_d = '0;
    if (!mem_stall) begin
      wb_d.valid    = mem_q.valid;
      wb_d.regWr    = mem_q.regWr;
      wb_d.memToReg = mem_q.memToReg;
      wb_d.destiny  = mem_q.destiny;
      wb_d.aluOut   = mem_q.aluOut;
      wb_d.pc       = mem_q.pc;
      wb_d.rdata    = dataOk ? mem_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign mem_we    = mem_q.memWr;
  assign mem_addr  = mem_q.aluOut;
  assign mem_wdata = mem_q.dataB;

  assign WB_RegWr   = wb_q.valid & wb_q.regWr & (wb_q.destiny != REG_ZERO);
  assign WB_Destiny = wb_q.destiny;

  always_comb begin
    case (wb_q.memToReg)
      MTR_MEM: WB_out = wb_q.rdata;
      MTR_PC:  WB_out = wb_q.pc;
      default: WB_out = wb_q.aluOut;
    endcase
  end

  // Load data is not available in MEM, so a matching load stalls decode instead.
  assign Mem_in      = (mem_q.memToReg == MTR_PC) ? mem_q.pc : mem_q.aluOut;
  assign hitRs       = mem_q.valid & mem_q.regWr & (mem_q.destiny != REG_ZERO) & (mem_q.destiny == ID_rs);
  assign hitRt       = mem_q.valid & mem_q.regWr & (mem_q.destiny != REG_ZERO) & (mem_q.destiny == ID_rt);
  assign ForwardC    = hitRs & (mem_q.memToReg != MTR_MEM);
  assign ForwardD    = hitRt & (mem_q.memToReg != MTR_MEM);
  assign load_hazard = (hitRs | hitRt) & (mem_q.memToReg == MTR_MEM);

endmodule

// File: tb/tb_pipeline_mem_wb.sv
// Self-checking bench for pipeline_mem_wb: directed vector table, multi-cycle
// handshake sequences, and a random stream checked by a write-order scoreboard.
module tb_pipeline_mem_wb;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] datab;
    logic [31:0] pc;
    logic [1:0]  mtr;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic [4:0]  dest;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      ins;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] expMemIn;
    logic [3:0]  expFlags;
    logic        expWbWr;
    logic [4:0]  expWbDest;
    logic [31:0] expWbOut;
  } vec_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] value;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_valid, EX_RegWr, EX_MemRd, EX_MemWr;
  logic [31:0] EX_ALUout, EX_dataB, EX_PC;
  logic [1:0]  EX_MemToReg;
  logic [4:0]  EX_Destiny, ID_rs, ID_rt;
  logic        mem_req, mem_we, mem_ack, mem_stall, load_hazard, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, Mem_in, WB_out;
  logic        ForwardC, ForwardD, WB_RegWr;
  logic [4:0]  WB_Destiny;

  int checks = 0;
  int errors = 0;

  vec_t        vecs[$];
  wr_t         expQ[$];
  logic [31:0] devMem[logic [31:0]];
  logic [31:0] refMem[logic [31:0]];

  pipeline_mem_wb #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .EX_valid(EX_valid), .EX_ALUout(EX_ALUout), .EX_dataB(EX_dataB), .EX_PC(EX_PC),
    .EX_MemToReg(EX_MemToReg), .EX_RegWr(EX_RegWr), .EX_MemRd(EX_MemRd), .EX_MemWr(EX_MemWr),
    .EX_Destiny(EX_Destiny), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .load_hazard(load_hazard), .mem_err(mem_err), .Mem_in(Mem_in),
    .ForwardC(ForwardC), .ForwardD(ForwardD),
    .WB_RegWr(WB_RegWr), .WB_Destiny(WB_Destiny), .WB_out(WB_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

  function automatic instr_t mkIns(logic v, logic [31:0] alu, logic [31:0] datab, logic [31:0] pc,
                                   logic [1:0] mtr, logic rw, logic rd, logic wr, logic [4:0] dest);
    instr_t i;
    i.valid = v; i.alu = alu; i.datab = datab; i.pc = pc; i.mtr = mtr;
    i.regwr = rw; i.memrd = rd; i.memwr = wr; i.dest = dest;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mkIns(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
  endfunction

  function automatic logic [31:0] initWord(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] refRead(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] devRead(logic [31:0] a);
    return devMem.exists(a) ? devMem[a] : initWord(a);
  endfunction

  task automatic applyStimulus(input instr_t i);
    EX_valid    = i.valid;
    EX_ALUout   = i.alu;
    EX_dataB    = i.datab;
    EX_PC       = i.pc;
    EX_MemToReg = i.mtr;
    EX_RegWr    = i.regwr;
    EX_MemRd    = i.memrd;
    EX_MemWr    = i.memwr;
    EX_Destiny  = i.dest;
  endtask

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input instr_t ins, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ack, input logic [31:0] rdata, input logic [31:0] memIn,
                        input logic [3:0] flags, input logic wbWr, input logic [4:0] wbDest,
                        input logic [31:0] wbOut);
    vec_t v;
    v.name = name; v.ins = ins; v.rs = rs; v.rt = rt; v.ack = ack; v.rdata = rdata;
    v.expMemIn = memIn; v.expFlags = flags; v.expWbWr = wbWr; v.expWbDest = wbDest; v.expWbOut = wbOut;
    vecs.push_back(v);
  endtask

  function automatic logic [159:0] allOutputs();
    return {19'h0, mem_req, mem_we, mem_addr, mem_wdata, mem_stall, load_hazard, mem_err,
            Mem_in, ForwardC, ForwardD, WB_RegWr, WB_Destiny, WB_out};
  endfunction

  function automatic instr_t genInstr();
    instr_t  i;
    int      kind;
    logic [31:0] addr;
    logic [1:0]  mtrSel[3];
    mtrSel[0] = 2'b00; mtrSel[1] = 2'b10; mtrSel[2] = 2'b11;
    kind = $urandom_range(0, 9);
    addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
    i = mkIns(1'b1, $urandom, $urandom, $urandom & 32'hFFFF_FFFC, mtrSel[$urandom_range(0, 2)],
              ($urandom_range(0, 4) != 0), 1'b0, 1'b0, 5'($urandom_range(0, 31)));
    if (kind <= 2) begin
      i.alu = addr; i.mtr = 2'b01; i.memrd = 1'b1; i.regwr = 1'b1;
    end else if (kind <= 4) begin
      i.alu = addr; i.mtr = 2'b00; i.memwr = 1'b1; i.regwr = 1'b0;
    end else if (kind == 5) begin
      i.valid = 1'b0;
    end
    return i;
  endfunction

  // Retire model: what the register file must see, in program order.
  task automatic consume(input instr_t i);
    wr_t  w;
    logic al;
    al = (i.alu[1:0] == 2'b00);
    if (i.valid && i.memwr && al) refMem[i.alu] = i.datab;
    if (i.valid && i.regwr && i.dest != 5'd0) begin
      w.dest = i.dest;
      if (i.mtr == 2'b10)      w.value = i.pc;
      else if (i.mtr == 2'b01) w.value = (i.memrd && al) ? refRead(i.alu) : 32'h0;
      else                     w.value = i.alu;
      expQ.push_back(w);
    end
  endtask

  // Random phase: bench acts as driver, variable-latency memory and scoreboard.
  task automatic runRandom(input int cycles, input int drain);
    instr_t exI, memI;
    logic   prevStall, reqActive, acc, al;
    int     waitLeft;
    exI = bubble(); memI = bubble();
    prevStall = 1'b0; reqActive = 1'b0; waitLeft = 0;
    for (int c = 0; c < cycles + drain; c++) begin
      @(negedge clk);
      if (!prevStall) begin
        memI = exI;
        consume(memI);
        exI = (c < cycles) ? genInstr() : bubble();
        applyStimulus(exI);
      end
      ID_rs = ($urandom_range(0, 1) != 0) ? memI.dest : 5'($urandom_range(0, 31));
      ID_rt = ($urandom_range(0, 1) != 0) ? memI.dest : 5'($urandom_range(0, 31));
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!reqActive) begin
          reqActive = 1'b1;
          waitLeft = $urandom_range(0, 3);
        end
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          if (mem_we) devMem[mem_addr] = mem_wdata;
          else        mem_rdata = devRead(mem_addr);
          reqActive = 1'b0;
        end else begin
          waitLeft--;
        end
      end else begin
        reqActive = 1'b0;
      end
      #1;
      acc = memI.valid & (memI.memrd | memI.memwr);
      al  = (memI.alu[1:0] == 2'b00);
      checkOutput("rnd_req_err_stall", {mem_req, mem_err, mem_stall}, {acc & al, acc & ~al, acc & al & ~mem_ack});
      checkOutput("rnd_mem_in", Mem_in, (memI.mtr == 2'b10) ? memI.pc : memI.alu);
      begin
        logic hs, ht, ld;
        hs = memI.valid & memI.regwr & (memI.dest != 0) & (memI.dest == ID_rs);
        ht = memI.valid & memI.regwr & (memI.dest != 0) & (memI.dest == ID_rt);
        ld = (memI.mtr == 2'b01);
        checkOutput("rnd_forward", {ForwardC, ForwardD, load_hazard}, {hs & ~ld, ht & ~ld, (hs | ht) & ld});
      end
      if (WB_RegWr) begin
        if (expQ.size() == 0) checkOutput("rnd_wb_unexpected", {WB_Destiny, WB_out}, 37'h0);
        else begin
          wr_t w;
          w = expQ.pop_front();
          checkOutput("rnd_wb_write", {WB_Destiny, WB_out}, {w.dest, w.value});
        end
      end
      prevStall = mem_stall;
    end
    checkOutput("rnd_scoreboard_drained", 160'(expQ.size()), 160'd0);
  endtask

  initial begin
    int stallCnt, reqCnt, wbCnt, errCnt;
    logic [31:0] wbData;

    reset = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; ID_rs = 5'd8; ID_rt = 5'd9;
    applyStimulus(mkIns(1'b1, 32'h1234, 32'h1, 32'h4, 2'b01, 1'b1, 1'b1, 1'b0, 5'd8));
    repeat (3) @(negedge clk);
    #1 checkOutput("reset_all_zero", allOutputs(), 160'h0);
    applyStimulus(bubble());
    @(negedge clk) reset = 1'b1;

    // Directed table: flags = {ForwardC, ForwardD, load_hazard, mem_req} ; mem_err checked separately.
    addVec("add_t0",     mkIns(1, 32'h1234, 0, 32'h404, 2'b00, 1, 0, 0, 5'd8),  5'd8,  5'd3,  0, 0,            32'h1234, 4'b1000, 1, 5'd8,  32'h1234);
    addVec("jal_ra",     mkIns(1, 32'h5555, 0, 32'h408, 2'b10, 1, 0, 0, 5'd31), 5'd31, 5'd31, 0, 0,            32'h408,  4'b1100, 1, 5'd31, 32'h408);
    addVec("lw_hazard",  mkIns(1, 32'h100,  0, 32'h40C, 2'b01, 1, 1, 0, 5'd9),  5'd2,  5'd9,  1, 32'hDEADBEEF, 32'h100,  4'b0011, 1, 5'd9,  32'hDEADBEEF);
    addVec("lw_misalign",mkIns(1, 32'h102,  0, 32'h410, 2'b01, 1, 1, 0, 5'd10), 5'd4,  5'd10, 0, 32'hFFFFFFFF, 32'h102,  4'b0010, 1, 5'd10, 32'h0);
    addVec("write_r0",   mkIns(1, 32'h77,   0, 32'h414, 2'b00, 1, 0, 0, 5'd0),  5'd0,  5'd0,  0, 0,            32'h77,   4'b0000, 0, 5'd0,  32'h77);
    addVec("mtr_11",     mkIns(1, 32'hCAFE, 0, 32'h500, 2'b11, 1, 0, 0, 5'd5),  5'd5,  5'd6,  0, 0,            32'hCAFE, 4'b1000, 1, 5'd5,  32'hCAFE);
    addVec("bubble",     mkIns(0, 32'h99,   0, 32'h504, 2'b00, 1, 0, 0, 5'd7),  5'd7,  5'd7,  0, 0,            32'h99,   4'b0000, 0, 5'd7,  32'h99);
    addVec("sw_ack",     mkIns(1, 32'h104, 32'hABCD, 32'h508, 2'b00, 0, 0, 1, 5'd0), 5'd0, 5'd1, 1, 0,        32'h104,  4'b0001, 0, 5'd0,  32'h104);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].ins);
      ID_rs = vecs[i].rs; ID_rt = vecs[i].rt;
      @(negedge clk);
      applyStimulus(bubble());
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      #1;
      checkOutput({vecs[i].name, "_mem_in"}, Mem_in, vecs[i].expMemIn);
      checkOutput({vecs[i].name, "_flags"}, {ForwardC, ForwardD, load_hazard, mem_req}, vecs[i].expFlags);
      checkOutput({vecs[i].name, "_err_stall"}, {mem_err, mem_stall},
                  {vecs[i].ins.valid & (vecs[i].ins.memrd | vecs[i].ins.memwr) & (vecs[i].ins.alu[1:0] != 0), 1'b0});
      if (vecs[i].ins.memwr) checkOutput({vecs[i].name, "_store_port"}, {mem_we, mem_wdata}, {1'b1, vecs[i].ins.datab});
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1 checkOutput({vecs[i].name, "_wb"}, {WB_RegWr, WB_Destiny, WB_out},
                     {vecs[i].expWbWr, vecs[i].expWbDest, vecs[i].expWbOut});
    end

    // Load with three wait cycles: ack arrives on the fourth cycle of the access.
    repeat (2) @(negedge clk);
    applyStimulus(mkIns(1, 32'h100, 0, 32'h600, 2'b01, 1, 1, 0, 5'd11));
    stallCnt = 0; reqCnt = 0; wbCnt = 0; wbData = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(bubble());
      mem_ack = (c == 3);
      mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      #1;
      stallCnt += int'(mem_stall);
      reqCnt   += int'(mem_req);
      if (WB_RegWr) begin wbCnt++; wbData = WB_out; end
    end
    mem_ack = 1'b0;
    checkOutput("lw_wait_stall_cycles", 160'(stallCnt), 160'd3);
    checkOutput("lw_wait_req_cycles", 160'(reqCnt), 160'd4);
    checkOutput("lw_wait_retire_once", 160'(wbCnt), 160'd1);
    checkOutput("lw_wait_data", wbData, 32'hDEADBEEF);

    // Store that is never acknowledged: watchdog forces completion.
    applyStimulus(mkIns(1, 32'h200, 32'h5A5A, 32'h700, 2'b00, 0, 0, 1, 5'd0));
    stallCnt = 0; errCnt = 0; wbCnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) applyStimulus(bubble());
      mem_ack = 1'b0;
      #1;
      stallCnt += int'(mem_stall);
      errCnt   += int'(mem_err);
      wbCnt    += int'(WB_RegWr);
    end
    checkOutput("sw_timeout_stall_cycles", 160'(stallCnt), 160'd15);
    checkOutput("sw_timeout_err_pulses", 160'(errCnt), 160'd1);
    checkOutput("sw_timeout_no_write", 160'(wbCnt), 160'd0);
    checkOutput("sw_timeout_advanced", {mem_req, mem_stall}, 2'b00);

    // Asynchronous reset in the middle of a waiting access.
    applyStimulus(mkIns(1, 32'h300, 0, 32'h800, 2'b01, 1, 1, 0, 5'd12));
    ID_rs = 5'd12; ID_rt = 5'd12;
    @(negedge clk);
    applyStimulus(bubble());
    @(negedge clk);
    #1 checkOutput("pre_reset_waiting", {mem_req, mem_stall}, 2'b11);
    #2 reset = 1'b0;
    #1 checkOutput("reset_mid_wait_all_zero", allOutputs(), 160'h0);
    @(negedge clk) reset = 1'b1;
    applyStimulus(mkIns(1, 32'h204, 0, 32'h900, 2'b01, 1, 1, 0, 5'd13));
    @(negedge clk);
    applyStimulus(bubble());
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    #1 checkOutput("post_reset_lw_zero_wait", {mem_req, mem_stall}, 2'b10);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1 checkOutput("post_reset_lw_wb", {WB_RegWr, WB_Destiny, WB_out}, {1'b1, 5'd13, 32'h13579BDF});

    @(negedge clk);
    runRandom(400, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
